// File: rtl/aes_s2mm_fsm.sv
// aes_s2mm_fsm: serialises 128-bit AES result blocks into four 32-bit S2MM beats with sof/eof pulses.
// Build option AES_S2MM_BSWAP_EN byte-reverses every beat to match big-endian AES byte order.
module aes_s2mm_fsm #(
    parameter int C_M_AXIS_S2MM_TDATA_WIDTH = 32,
    parameter int C_AES_DATA_WIDTH          = 128,
    parameter     C_FAMILY                  = "virtex6"
) (
    input  logic                                   m_axi_mm2s_aclk,
    input  logic                                   s2mm_prmry_reset_out_n,
    input  logic [C_AES_DATA_WIDTH-1:0]            aes_out_data,
    input  logic                                   aes_out_valid,
    input  logic                                   aes_out_last,
    output logic                                   aes_out_ready,
    output logic [C_M_AXIS_S2MM_TDATA_WIDTH-1:0]   m_axis_s2mm_tdata,
    output logic [3:0]                             m_axis_s2mm_tkeep,
    output logic                                   m_axis_s2mm_tvalid,
    output logic                                   m_axis_s2mm_tlast,
    input  logic                                   m_axis_s2mm_tready,
    input  logic                                   aes_sts_ready,
    output logic                                   aes_s2mm_sof,
    output logic                                   aes_s2mm_eof,
    output logic [31:0]                            aes_s2mm_dbg
);

    if (C_M_AXIS_S2MM_TDATA_WIDTH != 32 || C_AES_DATA_WIDTH != 128) begin : g_bad_cfg
        $error("aes_s2mm_fsm (%s): only 32-bit beats of 128-bit blocks are supported", C_FAMILY);
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_WAIT = 3'd2,
        S_GAP  = 3'd3
    } state_t;

    state_t                        state, state_nxt;
    logic [1:0]                    word_cnt, word_cnt_nxt;
    logic [15:0]                   blk_cnt, blk_cnt_nxt;
    logic [1:0]                    gap_cnt, gap_cnt_nxt;
    logic                          blk_last, blk_last_nxt;
    logic                          sof_nxt, eof_nxt;
    logic [C_AES_DATA_WIDTH-1:0]   blk_q;
    logic [31:0]                   word;
    logic                          hs, last_word_hs, capture;

    assign hs           = m_axis_s2mm_tvalid & m_axis_s2mm_tready;
    assign last_word_hs = hs & (word_cnt == 2'd3);
    assign capture      = aes_out_valid & aes_out_ready;

    always_comb begin
        aes_out_ready = 1'b0;
        if (s2mm_prmry_reset_out_n) begin
            case (state)
                S_IDLE:  aes_out_ready = aes_sts_ready;
                S_WAIT:  aes_out_ready = 1'b1;
                S_DATA:  aes_out_ready = last_word_hs & ~blk_last;
                default: aes_out_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        blk_cnt_nxt  = blk_cnt;
        gap_cnt_nxt  = gap_cnt;
        blk_last_nxt = blk_last;
        sof_nxt      = 1'b0;
        eof_nxt      = 1'b0;
        case (state)
            S_IDLE: begin
                if (capture) begin
                    sof_nxt     = 1'b1;
                    blk_cnt_nxt = 16'd1;
                    state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (hs) begin
                    if (word_cnt != 2'd3) begin
                        word_cnt_nxt = word_cnt + 2'd1;
                    end else if (blk_last) begin
                        eof_nxt     = 1'b1;
                        gap_cnt_nxt = 2'd2;
                        state_nxt   = S_GAP;
                    end else if (capture) begin
                        if (blk_cnt != 16'hFFFF) blk_cnt_nxt = blk_cnt + 16'd1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (capture) begin
                    if (blk_cnt != 16'hFFFF) blk_cnt_nxt = blk_cnt + 16'd1;
                    state_nxt = S_DATA;
                end
            end
            S_GAP: begin
                // Hold off new frames until aes_sts_ready has caught up with the eof.
                gap_cnt_nxt = gap_cnt - 2'd1;
                if (gap_cnt <= 2'd1) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (capture) begin
            blk_last_nxt = aes_out_last;
            word_cnt_nxt = 2'd0;
        end
    end

    always_ff @(posedge m_axi_mm2s_aclk) begin
        if (!s2mm_prmry_reset_out_n) begin
            state        <= S_IDLE;
            word_cnt     <= 2'd0;
            blk_cnt      <= 16'd0;
            gap_cnt      <= 2'd0;
            blk_last     <= 1'b0;
            aes_s2mm_sof <= 1'b0;
            aes_s2mm_eof <= 1'b0;
        end else begin
            state        <= state_nxt;
            word_cnt     <= word_cnt_nxt;
            blk_cnt      <= blk_cnt_nxt;
            gap_cnt      <= gap_cnt_nxt;
            blk_last     <= blk_last_nxt;
            aes_s2mm_sof <= sof_nxt;
            aes_s2mm_eof <= eof_nxt;
        end
    end

    // Capture can never fire during reset because aes_out_ready is forced low.
    always_ff @(posedge m_axi_mm2s_aclk) begin
        if (capture) blk_q <= aes_out_data;
    end

    assign word = blk_q[{word_cnt, 5'd0} +: 32];

`ifdef AES_S2MM_BSWAP_EN
    assign m_axis_s2mm_tdata = {word[7:0], word[15:8], word[23:16], word[31:24]};
`else
    assign m_axis_s2mm_tdata = word;
`endif

    assign m_axis_s2mm_tkeep  = 4'hf;
    assign m_axis_s2mm_tvalid = (state == S_DATA);
    assign m_axis_s2mm_tlast  = (state == S_DATA) & (word_cnt == 2'd3) & blk_last;
    assign aes_s2mm_dbg       = {blk_cnt, 10'd0, word_cnt, 1'b0, state};

endmodule

// File: tb/tb_aes_s2mm_fsm.sv
// tb_aes_s2mm_fsm: directed + randomized bench for aes_s2mm_fsm with a queue-based beat model.
// Honours AES_S2MM_BSWAP_EN when computing expected beats.
module tb_aes_s2mm_fsm;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] aes_out_data = '0;
    logic         aes_out_valid = 1'b0;
    logic         aes_out_last = 1'b0;
    logic         aes_out_ready;
    logic [31:0]  tdata;
    logic [3:0]   tkeep;
    logic         tvalid, tlast;
    logic         tready = 1'b0;
    logic         sts_ready = 1'b0;
    logic         sof, eof;
    logic [31:0]  dbg;

    int checks = 0;
    int errors = 0;

    beat_t q[$];
    beat_t b;
    logic  mon_hs, mon_cap;
    bit    in_frame, pend_sof, pend_eof;
    int    blocks, cyc, sof_cnt, eof_cnt, frame_beats, reload_mask;
    int    first_hs_cyc, last_hs_cyc, dbg_at_tlast, start_gap;
    int    eof_seen_cyc = -1000;
    int    treadyMode = 0;
    int    tcnt = 0;

    always #5 clk = ~clk;

    aes_s2mm_fsm dut (
        .m_axi_mm2s_aclk        (clk),
        .s2mm_prmry_reset_out_n (rst_n),
        .aes_out_data           (aes_out_data),
        .aes_out_valid          (aes_out_valid),
        .aes_out_last           (aes_out_last),
        .aes_out_ready          (aes_out_ready),
        .m_axis_s2mm_tdata      (tdata),
        .m_axis_s2mm_tkeep      (tkeep),
        .m_axis_s2mm_tvalid     (tvalid),
        .m_axis_s2mm_tlast      (tlast),
        .m_axis_s2mm_tready     (tready),
        .aes_sts_ready          (sts_ready),
        .aes_s2mm_sof           (sof),
        .aes_s2mm_eof           (eof),
        .aes_s2mm_dbg           (dbg)
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expWord(input logic [127:0] blk, input int idx);
        logic [31:0] w;
        w = blk[idx*32 +: 32];
`ifdef AES_S2MM_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model: every captured block queues four beats; the stream must replay the queue.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            in_frame = 0;
            pend_sof = 0;
            pend_eof = 0;
            blocks   = 0;
        end else begin
            checkOutput("sof", sof, pend_sof);
            checkOutput("eof", eof, pend_eof);
            checkOutput("sof_eof_overlap", sof & eof, 0);
            checkOutput("tvalid", tvalid, q.size() != 0);
            checkOutput("tkeep", tkeep, 4'hf);
            checkOutput("dbg_blocks", dbg[31:16], blocks);
            if (q.size() != 0) begin
                checkOutput("tdata", tdata, q[0].data);
                checkOutput("tlast", tlast, q[0].last);
                checkOutput("dbg_word_cnt", dbg[5:4], 4 - q.size());
            end
            if (sof) sof_cnt++;
            if (eof) begin
                eof_cnt++;
                eof_seen_cyc = cyc;
            end
            pend_sof = 0;
            pend_eof = 0;
            mon_hs  = tvalid & tready;
            mon_cap = aes_out_valid & aes_out_ready;
            if (mon_hs && q.size() != 0) begin
                b = q.pop_front();
                frame_beats++;
                if (frame_beats == 1) first_hs_cyc = cyc;
                if (mon_cap) reload_mask |= (1 << frame_beats);
                if (b.last) begin
                    pend_eof     = 1;
                    in_frame     = 0;
                    last_hs_cyc  = cyc;
                    dbg_at_tlast = int'(dbg[31:16]);
                end
            end
            if (mon_cap) begin
                if (!in_frame) begin
                    in_frame    = 1;
                    pend_sof    = 1;
                    blocks      = 1;
                    frame_beats = 0;
                    reload_mask = 0;
                    start_gap   = cyc - eof_seen_cyc;
                end else if (blocks < 65535) begin
                    blocks++;
                end
                for (int i = 0; i < 4; i++) begin
                    b.data = expWord(aes_out_data, i);
                    b.last = aes_out_last && (i == 3);
                    q.push_back(b);
                end
            end
        end
    end

    // tready patterns: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            case (treadyMode)
                0:       tready = 1'b1;
                1:       tready = (tcnt % 3 == 0);
                default: tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [127:0] data, input logic last);
        bit got = 0;
        aes_out_data  = data;
        aes_out_last  = last;
        aes_out_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (aes_out_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) checkOutput("capture_timeout", 0, 1);
        tick();
        aes_out_valid = 1'b0;
        aes_out_data  = rand128();
    endtask

    task automatic waitIdle(input string tag);
        bit done = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0 && !in_frame && !pend_eof) begin
                done = 1;
                break;
            end
        end
        if (!done) checkOutput({tag, "_timeout"}, 0, 1);
        repeat (4) tick();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s0, e0, n;

        // Reset with a block offered: nothing may be accepted or emitted.
        sts_ready     = 1'b1;
        aes_out_valid = 1'b1;
        aes_out_last  = 1'b1;
        aes_out_data  = rand128();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", aes_out_ready, 0);
        checkOutput("rst_tvalid", tvalid, 0);
        checkOutput("rst_tlast", tlast, 0);
        checkOutput("rst_sof", sof, 0);
        checkOutput("rst_eof", eof, 0);
        checkOutput("rst_dbg", dbg, 0);
        tick();
        aes_out_valid = 1'b0;
        rst_n         = 1'b1;
        tick();

        // Single-block frames, including one of distinct bytes for the swap build.
        applyStimulus(128'h33333333_22222222_11111111_00000000, 1'b1);
        waitIdle("single");
        checkOutput("single_sof_cnt", sof_cnt, 1);
        checkOutput("single_eof_cnt", eof_cnt, 1);
        applyStimulus(128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b1);
        waitIdle("single_bytes");
        checkOutput("bytes_sof_cnt", sof_cnt, 2);
        checkOutput("bytes_eof_cnt", eof_cnt, 2);

        // Three-block frame with valid held and tready high: 12 gap-free beats.
        for (int i = 0; i < 3; i++) applyStimulus(rand128(), i == 2);
        waitIdle("three_blk");
        checkOutput("b2b_span", last_hs_cyc - first_hs_cyc, 11);
        checkOutput("b2b_reload_beats", reload_mask, (1 << 4) | (1 << 8));
        checkOutput("b2b_dbg_blocks", dbg_at_tlast, 3);

        // Stalling sink.
        treadyMode = 1;
        for (int i = 0; i < 2; i++) applyStimulus(rand128(), i == 1);
        waitIdle("stall");
        treadyMode = 0;

        // Status FSM not ready: block must be held off, then taken promptly.
        sts_ready     = 1'b0;
        aes_out_data  = rand128();
        aes_out_last  = 1'b1;
        aes_out_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("held_ready", aes_out_ready, 0);
            checkOutput("held_sof", sof, 0);
        end
        tick();
        sts_ready = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_sts", aes_out_ready, 1);
        tick();
        aes_out_valid = 1'b0;
        @(negedge clk);
        checkOutput("sof_after_sts", sof, 1);
        waitIdle("sts_hold");

        // Reset after the second beat drops the frame silently.
        e0 = eof_cnt;
        applyStimulus(rand128(), 1'b1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (frame_beats >= 2) break;
        end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_tvalid", tvalid, 0);
        checkOutput("midrst_state", dbg[2:0], 0);
        checkOutput("midrst_eof", eof, 0);
        tick();
        checkOutput("midrst_no_eof", eof_cnt, e0);
        s0 = sof_cnt;
        applyStimulus(rand128(), 1'b1);
        waitIdle("after_rst");
        checkOutput("after_rst_sof", sof_cnt, s0 + 1);
        checkOutput("after_rst_eof", eof_cnt, e0 + 1);

        // Back-to-back single-block frames respect the post-eof gap.
        applyStimulus(rand128(), 1'b1);
        applyStimulus(rand128(), 1'b1);
        checkOutput("gap_after_eof", start_gap >= 2, 1);
        waitIdle("b2b_frames");

        // Random frames, sink patterns and inter-block delays.
        e0 = eof_cnt;
        for (int f = 0; f < 8; f++) begin
            treadyMode = $urandom_range(0, 2);
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                applyStimulus(rand128(), i == n - 1);
            end
            waitIdle("random");
        end
        checkOutput("random_eof_cnt", eof_cnt, e0 + 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_s2mm_fsm.md
Name: aes_s2mm_fsm

Overview:
- S2MM output stage of the AXI AES core, upstream of aes_sts_fsm.
- Accepts 128-bit result blocks from the AES engine and serialises each into four 32-bit beats on the AXI DMA S2MM data stream.
- Asserts tlast on the final beat of a frame.
- Emits the aes_s2mm_sof/aes_s2mm_eof pulses consumed by aes_sts_fsm, and admits a new frame only while aes_sts_ready is high.

Parameters:
- C_M_AXIS_S2MM_TDATA_WIDTH, 32: S2MM data width. Only 32 is supported.
- C_AES_DATA_WIDTH, 128: engine block width. Only 128 is supported, giving 4 beats per block.
- C_FAMILY, "virtex6": target family, passed through and otherwise unused.

Ports:
- m_axi_mm2s_aclk  in  1  single core clock; every register is in this domain.
- s2mm_prmry_reset_out_n  in  1  synchronous active-low reset.
- aes_out_data  in  128  engine result block; word0 = [31:0], word3 = [127:96].
- aes_out_valid  in  1  block valid.
- aes_out_last  in  1  block is the last block of its frame; qualified by aes_out_valid.
- aes_out_ready  out  1  block accepted when aes_out_valid & aes_out_ready.
- m_axis_s2mm_tdata  out  32  S2MM beat.
- m_axis_s2mm_tkeep  out  4  constant 4'hf.
- m_axis_s2mm_tvalid  out  1  beat valid.
- m_axis_s2mm_tlast  out  1  last beat of frame.
- m_axis_s2mm_tready  in  1  DMA accepts the beat.
- aes_sts_ready  in  1  status FSM can accept a new frame.
- aes_s2mm_sof  out  1  one-cycle pulse when a frame's first block is captured.
- aes_s2mm_eof  out  1  one-cycle pulse on the tlast handshake.
- aes_s2mm_dbg  out  32  debug word: [2:0] state, [5:4] word_cnt, [31:16] blocks in the current frame.

Behaviour:
- Reset: s2mm_prmry_reset_out_n low at a clock edge sets:
  - state to S_IDLE;
  - word_cnt, blk_cnt, gap_cnt and blk_last to 0;
  - m_axis_s2mm_tvalid, m_axis_s2mm_tlast, aes_s2mm_sof and aes_s2mm_eof to 0.
- aes_out_ready is forced to 0 while reset is low.
- Reset mid-frame drops the frame; no eof pulse is generated.
- Storage: one 128-bit block register, 2-bit word_cnt, blk_last flag, 16-bit blk_cnt that saturates at 16'hFFFF.
- Output mux: m_axis_s2mm_tdata = block[32*word_cnt +: 32].
- m_axis_s2mm_tvalid = (state == S_DATA).
- m_axis_s2mm_tlast = (state == S_DATA) & (word_cnt == 3) & blk_last.
- Beat handshake: hs = tvalid & tready. tdata, tlast and word_cnt are stable while tvalid is high and tready is low.
- aes_out_ready is combinational:
  - high in S_IDLE when aes_sts_ready is high;
  - high in S_WAIT;
  - high in S_DATA when word_cnt == 3, hs is high and blk_last is 0 (back-to-back block reload).
- A capture happens on aes_out_valid & aes_out_ready. It loads the block register and blk_last, and clears word_cnt.
- States:
  - S_IDLE: on capture, pulse aes_s2mm_sof for exactly one cycle (registered, asserted the cycle after capture), set blk_cnt = 1, go to S_DATA.
  - S_DATA: on hs with word_cnt < 3, increment word_cnt.
    - On hs with word_cnt == 3 and blk_last == 0: if a capture occurs in the same cycle, increment blk_cnt and stay in S_DATA with no bubble; otherwise go to S_WAIT.
    - On hs with word_cnt == 3 and blk_last == 1: pulse aes_s2mm_eof (registered, the cycle after hs) and go to S_GAP with gap_cnt = 2.
  - S_WAIT: tvalid is low. On capture, increment blk_cnt and go to S_DATA.
  - S_GAP: decrement gap_cnt each cycle; go to S_IDLE when it reaches 0. This covers the two-register latency of aes_sts_ready after eof, so S_IDLE never sees a stale ready.
- A single-block frame (aes_out_last = 1 on the first block) produces sof, 4 beats with tlast on the 4th, then eof.
- aes_out_valid while aes_sts_ready is low in S_IDLE: the block is held off (ready = 0) with no loss.
- sof and eof are never high in the same cycle. The minimum spacing is 4 cycles, one block of 4 beats.

Optional Feature:
- Macro AES_S2MM_BSWAP_EN.
- Defined: each 32-bit beat is byte-reversed, i.e. tdata = {w[7:0], w[15:8], w[23:16], w[31:24]} for w = block[32*word_cnt +: 32]. This matches the big-endian AES byte order on the bus.
- Undefined: the word is passed unchanged.
- Timing and control are identical in both builds.

Test Plan:
- Reset, then a single block 128'h33333333_22222222_11111111_00000000 with last = 1 and tready always 1:
  - sof pulses once;
  - beats are 00000000, 11111111, 22222222, 33333333;
  - tlast only on the 4th beat;
  - eof pulses once the cycle after it.
  - With AES_S2MM_BSWAP_EN defined, the beats are the byte-reversed words; 11111111 stays 11111111, so use a block of distinct bytes to check the swap.
- 3-block frame with aes_out_valid held high and tready = 1:
  - 12 consecutive beats with no tvalid gap;
  - aes_out_ready pulses on the 4th and 8th beat handshakes;
  - dbg[31:16] = 3 before eof.
- tready toggling 1,0,0,1,...:
  - tdata and tlast hold during stalls;
  - the beat order is preserved;
  - no duplicated or dropped words.
- aes_sts_ready = 0 with aes_out_valid = 1 in S_IDLE:
  - aes_out_ready stays 0 and no sof appears for 10 cycles;
  - after aes_sts_ready rises, capture and sof follow within 1 cycle.
- Reset asserted after the 2nd beat of a frame:
  - the next cycle shows tvalid = 0, state = 0 and no eof;
  - the next frame starts cleanly with sof.
- Two back-to-back single-block frames:
  - the second capture occurs no earlier than 2 cycles after eof (S_GAP);
  - sof and eof never overlap.
